imem_loader: RTL and testbench

Boot-time program loader on the write side of the instruction memory. It receives a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them into the `memory2c` instruction memory through its write port. It holds the core in reset until the image is fully written. It sits between an external host link and `imem`, with the core's `rst` driven from `core_rst_n`.

---
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the core in reset until done.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        mem_en,
    output logic        mem_wr,
    output logic        core_rst_n,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_idx_q, word_idx_d;
    logic [31:0] count_q, count_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] hdr_word;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_HDR;
            byte_cnt_q <= 2'd0;
            word_idx_q <= 32'd0;
            count_q    <= 32'd0;
            shift_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
        end
    end

    // Header value including the byte arriving this cycle
    assign hdr_word = {in_data, shift_q[23:0]};

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        shift_d    = shift_q;
        in_ready   = 1'b0;
        mem_addr   = 32'd0;
        mem_data   = 32'd0;
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        core_rst_n = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        unique case (state_q)
            S_HDR: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        count_d = hdr_word;
                        shift_d = 32'd0;
                        if (hdr_word == 32'd0)
                            state_d = S_DONE;
                        else if (hdr_word > 32'(MAX_WORDS))
                            state_d = S_ERR;
                        else
                            state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_en     = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = BASE_ADDR + {word_idx_q[29:0], 2'b00};
                mem_data   = shift_q;
                word_idx_d = word_idx_q + 32'd1;
                if (word_idx_q + 32'd1 == count_q)
                    state_d = S_DONE;
                else
                    state_d = S_LOAD;
            end
            S_DONE: begin
                done       = 1'b1;
                core_rst_n = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                state_d = S_HDR;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (default and
// BASE_ADDR=0x100/MAX_WORDS=4) checked every cycle against a stream model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_s [2];
    logic [7:0]  din   [2];
    logic        vld   [2];
    logic        rdy   [2];
    logic [31:0] maddr [2];
    logic [31:0] mdata [2];
    logic        men   [2];
    logic        mwr   [2];
    logic        crst  [2];
    logic        dn    [2];
    logic        er    [2];

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    imem_loader u0 (
        .clk(clk), .rst(rst_s[0]), .in_data(din[0]), .in_valid(vld[0]),
        .in_ready(rdy[0]), .mem_addr(maddr[0]), .mem_data(mdata[0]),
        .mem_en(men[0]), .mem_wr(mwr[0]), .core_rst_n(crst[0]),
        .done(dn[0]), .err(er[0])
    );

    imem_loader #(.BASE_ADDR(32'h100), .MAX_WORDS(4)) u1 (
        .clk(clk), .rst(rst_s[1]), .in_data(din[1]), .in_valid(vld[1]),
        .in_ready(rdy[1]), .mem_addr(maddr[1]), .mem_data(mdata[1]),
        .mem_en(men[1]), .mem_wr(mwr[1]), .core_rst_n(crst[1]),
        .done(dn[1]), .err(er[1])
    );

    task automatic chk(string nm, logic [69:0] act, logic [69:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] base_of(int i);
        return (i == 1) ? 32'h100 : 32'h0;
    endfunction

    function automatic int unsigned maxw_of(int i);
        return (i == 1) ? 4 : 1024;
    endfunction

    // Stream model: bytes accepted, header value, last four bytes, words done
    int unsigned nacc [2];
    logic [31:0] nm   [2];
    logic [31:0] wbuf [2];
    bit          pend [2];
    int unsigned ww   [2];

    function automatic bit m_done(int i);
        return nacc[i] >= 4 &&
               (nm[i] == 0 || (nm[i] <= maxw_of(i) && ww[i] == nm[i]));
    endfunction

    function automatic bit m_err(int i);
        return nacc[i] >= 4 && nm[i] > maxw_of(i);
    endfunction

    function automatic bit m_rdy(int i);
        return !m_done(i) && !m_err(i) && !pend[i];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_s[i]) begin
                nacc[i] = 0; nm[i] = 0; wbuf[i] = 0; pend[i] = 0; ww[i] = 0;
            end else if (pend[i]) begin
                pend[i] = 0;
                ww[i]++;
            end else if (m_rdy(i) && vld[i]) begin
                wbuf[i] = {din[i], wbuf[i][31:8]};
                nacc[i]++;
                if (nacc[i] == 4)
                    nm[i] = wbuf[i];
                else if (nacc[i] > 4 && nacc[i] % 4 == 0)
                    pend[i] = 1;
            end
        end
    end

    // Write log and a small instruction memory behind instance 0
    logic [31:0] la [2][16];
    logic [31:0] ld [2][16];
    int          nlog [2];
    logic [31:0] imem0 [16];

    always @(posedge clk)
        if (men[0] && mwr[0]) imem0[maddr[0][5:2]] = mdata[0];

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                logic [69:0] exp;
                exp = {m_rdy(i), pend[i], pend[i], m_done(i), m_done(i),
                       m_err(i),
                       pend[i] ? base_of(i) + 32'(4 * ww[i]) : 32'h0,
                       pend[i] ? wbuf[i] : 32'h0};
                chk($sformatf("outs%0d", i),
                    {rdy[i], men[i], mwr[i], crst[i], dn[i], er[i],
                     maddr[i], mdata[i]}, exp);
                if (mwr[i] && nlog[i] < 16) begin
                    la[i][nlog[i]] = maddr[i];
                    ld[i][nlog[i]] = mdata[i];
                    nlog[i]++;
                end
            end
        end
    end

    task automatic reset_inst(int i);
        @(posedge clk); #1;
        rst_s[i] = 1'b0;
        vld[i] = 1'b0;
        @(posedge clk); #1;
        rst_s[i] = 1'b1;
        nlog[i] = 0;
    endtask

    task automatic send(int i, logic [7:0] b, bit gap);
        bit took;
        if (gap) begin
            repeat ($urandom_range(0, 2)) begin
                vld[i] = 1'b0;
                din[i] = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        vld[i] = 1'b1;
        din[i] = b;
        for (int t = 0; t < 50; t++) begin
            took = rdy[i];
            @(posedge clk); #1;
            if (took) begin
                vld[i] = 1'b0;
                din[i] = 8'($urandom);
                return;
            end
        end
        tests++;
        fails++;
        vld[i] = 1'b0;
        $display("FAIL send_timeout: inst %0d byte %h never accepted", i, b);
    endtask

    task automatic send_word(int i, logic [31:0] w, bit gap);
        for (int k = 0; k < 4; k++) send(i, w[8*k +: 8], gap);
    endtask

    task automatic send_image(int i, int n, logic [31:0] w [16], bit gap);
        send_word(i, 32'(n), gap);
        for (int k = 0; k < n && k < 16; k++) send_word(i, w[k], gap);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_two_word(string nm);
        chk({nm, "_n"}, 70'(nlog[0]), 70'd2);
        chk({nm, "_w0"}, {la[0][0], ld[0][0]}, {32'h0, 32'h00000013});
        chk({nm, "_w1"}, {la[0][1], ld[0][1]}, {32'h4, 32'h00A00093});
        chk({nm, "_fin"}, {dn[0], crst[0], rdy[0], er[0]}, 4'b1100);
    endtask

    logic [31:0] w [16];

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b0; vld[i] = 1'b0; din[i] = 8'h0; nlog[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_s[0] = 1'b1;
        rst_s[1] = 1'b1;
        armed = 1'b1;
        chk("reset_state",
            {rdy[0], men[0], mwr[0], crst[0], dn[0], er[0], maddr[0], mdata[0]},
            70'h0 | (70'd1 << 69));

        // Two-word load, valid held high
        reset_inst(0);
        w[0] = 32'h00000013;
        w[1] = 32'h00A00093;
        send_image(0, 2, w, 1'b0);
        chk_two_word("t1");
        chk("t1_imem", 70'(imem0[1]), 70'h00A00093);

        // Empty image
        reset_inst(0);
        send_word(0, 32'h0, 1'b0);
        chk("t2_done_next", {dn[0], crst[0], rdy[0]}, 3'b110);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_nwr", 70'(nlog[0]), 70'd0);

        // Oversize header on the MAX_WORDS=4 instance
        reset_inst(1);
        send_word(1, 32'd5, 1'b0);
        chk("t3_err_next", {er[1], crst[1], rdy[1], dn[1]}, 4'b1000);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_nwr", 70'(nlog[1]), 70'd0);

        // Gapped valid with garbage data
        reset_inst(0);
        send_image(0, 2, w, 1'b1);
        chk_two_word("t4");

        // Reset after six bytes, then a one-word image
        reset_inst(0);
        send_word(0, 32'd2, 1'b0);
        send(0, 8'h13, 1'b0);
        send(0, 8'h00, 1'b0);
        reset_inst(0);
        chk("t5_rst_vals",
            {rdy[0], men[0], mwr[0], crst[0], dn[0], er[0], maddr[0], mdata[0]},
            70'd1 << 69);
        w[0] = 32'hDEADBEEF;
        send_image(0, 1, w, 1'b0);
        chk("t5_n", 70'(nlog[0]), 70'd1);
        chk("t5_w0", {la[0][0], ld[0][0]}, {32'h0, 32'hDEADBEEF});
        chk("t5_done", {dn[0], crst[0]}, 2'b11);

        // Base offset, three words
        reset_inst(1);
        for (int k = 0; k < 3; k++) w[k] = $urandom;
        send_image(1, 3, w, 1'b1);
        chk("t6_n", 70'(nlog[1]), 70'd3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t6_w%0d", k), {la[1][k], ld[1][k]},
                {32'h100 + 32'(4 * k), w[k]});
        chk("t6_done", {dn[1], er[1]}, 2'b10);

        // Random images on both instances
        for (int it = 0; it < 8; it++) begin
            int i;
            int n;
            int expn;
            i = it % 2;
            n = $urandom_range(0, 6);
            for (int k = 0; k < 16; k++) w[k] = $urandom;
            reset_inst(i);
            send_image(i, n, w, 1'($urandom));
            expn = (n <= int'(maxw_of(i))) ? n : 0;
            chk($sformatf("rnd%0d_n", it), 70'(nlog[i]), 70'(expn));
            for (int k = 0; k < expn; k++)
                chk($sformatf("rnd%0d_w%0d", it, k), {la[i][k], ld[i][k]},
                    {base_of(i) + 32'(4 * k), w[k]});
            chk($sformatf("rnd%0d_fin", it), {dn[i], er[i]},
                (n <= int'(maxw_of(i))) ? 2'b10 : 2'b01);
        end

        armed = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
